// File: rtl/tlb_op_ctrl.sv
// TLB operation controller: sequences SRCH/RD/WR/FILL/INV requests onto the
// TLB search, read and write ports and returns a single-cycle response.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    req_inv_op,
    input  logic [9:0]    req_asid,
    input  logic [18:0]   req_vppn,
    input  logic [IW-1:0] req_index,
    output logic [18:0]   s_vppn,
    output logic [9:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic          r_g,
    input  logic [18:0]   r_vppn,
    input  logic [9:0]    r_asid,
    input  logic [5:0]    r_ps,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic          w_from_rd,
    output logic          rd_en,
    output logic          resp_valid,
    output logic          resp_found,
    output logic [IW-1:0] resp_index,
    output logic          resp_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    logic [1:0]    state;
    logic [2:0]    op_q;
    logic [4:0]    inv_op_q;
    logic [9:0]    asid_q;
    logic [18:0]   vppn_q;
    logic [IW-1:0] index_q;
    logic [IW-1:0] fill_cnt;
    logic [IW-1:0] fill_q;
    logic [IW:0]   scan_idx;
    logic          resp_found_q;
    logic [IW-1:0] resp_index_q;
    logic          resp_err_q;

    logic          accept;
    logic          illegal;
    logic          scan_active;
    logic [IW-1:0] scan_k;
    logic          asid_eq;
    logic          va_eq;
    logic          hit;

    assign req_ready  = (state == ST_IDLE) && !reset;
    assign resp_valid = (state == ST_DONE) && !reset;
    assign accept     = req_valid && req_ready;
    assign illegal    = (req_op > OP_INV) || ((req_op == OP_INV) && (req_inv_op > 5'd6));

    assign resp_found = resp_found_q & ~reset;
    assign resp_index = reset ? '0 : resp_index_q;
    assign resp_err   = resp_err_q & ~reset;

    assign s_vppn = vppn_q;
    assign s_asid = asid_q;

    // The scan index runs one step past the last entry so the response
    // leaves a one-cycle gap after the final write opportunity.
    assign scan_active = (state == ST_SCAN) && (scan_idx < (IW+1)'(TLBNUM));
    assign scan_k      = scan_idx[IW-1:0];

    // Huge pages (ps=21) only compare the upper VPPN bits.
    assign asid_eq = (r_asid == asid_q);
    assign va_eq   = (r_ps == 6'd21) ? (r_vppn[18:10] == vppn_q[18:10])
                                     : (r_vppn == vppn_q);

    always_comb begin
        hit = 1'b0;
        case (inv_op_q)
            5'd0, 5'd1: hit = 1'b1;
            5'd2:       hit = r_g;
            5'd3:       hit = !r_g;
            5'd4:       hit = !r_g && asid_eq;
            5'd5:       hit = !r_g && asid_eq && va_eq;
            5'd6:       hit = (r_g || asid_eq) && va_eq;
            default:    hit = 1'b0;
        endcase
    end

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        we        = 1'b0;
        w_index   = '0;
        w_from_rd = 1'b0;
        r_index   = '0;
        rd_en     = 1'b0;
        if (!reset) begin
            case (state)
                ST_EXEC: begin
                    case (op_q)
                        OP_RD: begin
                            r_index = index_q;
                            rd_en   = 1'b1;
                        end
                        OP_WR: begin
                            we      = 1'b1;
                            w_index = index_q;
                        end
                        OP_FILL: begin
                            we      = 1'b1;
                            w_index = fill_q;
                        end
                        default: ;
                    endcase
                end
                ST_SCAN: begin
                    if (scan_active) begin
                        r_index = scan_k;
                        if (r_e && hit) begin
                            we        = 1'b1;
                            w_index   = scan_k;
                            w_from_rd = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: request fields are pure datapath captured on accept; only control
    // state and visible response registers need a reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            fill_cnt     <= '0;
            scan_idx     <= '0;
            resp_found_q <= 1'b0;
            resp_index_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            fill_cnt <= (fill_cnt == IW'(TLBNUM - 1)) ? '0 : fill_cnt + IW'(1);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q         <= req_op;
                        inv_op_q     <= req_inv_op;
                        asid_q       <= req_asid;
                        vppn_q       <= req_vppn;
                        index_q      <= req_index;
                        fill_q       <= fill_cnt;
                        scan_idx     <= '0;
                        resp_found_q <= 1'b0;
                        resp_index_q <= '0;
                        resp_err_q   <= illegal;
                        if (illegal)               state <= ST_DONE;
                        else if (req_op == OP_INV) state <= ST_SCAN;
                        else                       state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_SRCH) begin
                        resp_found_q <= s_found;
                        resp_index_q <= s_index;
                    end
                    state <= ST_DONE;
                end
                ST_SCAN: begin
                    if (scan_idx == (IW+1)'(TLBNUM)) state    <= ST_DONE;
                    else                             scan_idx <= scan_idx + (IW+1)'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a TLB array model, a response
// scoreboard and an expected-write queue.
module tb_tlb_op_ctrl;

    localparam int TLBNUM = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [4:0]    req_inv_op;
    logic [9:0]    req_asid;
    logic [18:0]   req_vppn;
    logic [IW-1:0] req_index;
    logic [18:0]   s_vppn;
    logic [9:0]    s_asid;
    logic          s_found;
    logic [IW-1:0] s_index;
    logic [IW-1:0] r_index;
    logic          r_e, r_g;
    logic [18:0]   r_vppn;
    logic [9:0]    r_asid;
    logic [5:0]    r_ps;
    logic          we;
    logic [IW-1:0] w_index;
    logic          w_from_rd;
    logic          rd_en;
    logic          resp_valid;
    logic          resp_found;
    logic [IW-1:0] resp_index;
    logic          resp_err;

    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_inv_op(req_inv_op), .req_asid(req_asid),
        .req_vppn(req_vppn), .req_index(req_index),
        .s_vppn(s_vppn), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
        .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_vppn(r_vppn),
        .r_asid(r_asid), .r_ps(r_ps),
        .we(we), .w_index(w_index), .w_from_rd(w_from_rd),
        .rd_en(rd_en), .resp_valid(resp_valid), .resp_found(resp_found),
        .resp_index(resp_index), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // TLB array model behind the read port.
    logic        tlb_e    [TLBNUM];
    logic        tlb_g    [TLBNUM];
    logic [18:0] tlb_vppn [TLBNUM];
    logic [9:0]  tlb_asid [TLBNUM];
    logic [5:0]  tlb_ps   [TLBNUM];

    assign r_e    = tlb_e[r_index];
    assign r_g    = tlb_g[r_index];
    assign r_vppn = tlb_vppn[r_index];
    assign r_asid = tlb_asid[r_index];
    assign r_ps   = tlb_ps[r_index];

    typedef struct {
        logic          found;
        logic [IW-1:0] index;
        logic          err;
        int            lat;
    } resp_t;

    typedef struct {
        logic [IW-1:0] index;
        logic          from_rd;
    } wr_t;

    resp_t sb[$];
    wr_t   wq[$];

    int errors = 0;
    int checks = 0;
    logic [IW-1:0] fill_model;

    always @(posedge clk) begin
        if (reset) fill_model <= '0;
        else       fill_model <= (fill_model == IW'(TLBNUM - 1)) ? '0 : fill_model + IW'(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write seen on the port must match the next expected write.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (wq.size() == 0) begin
                check("we_unexpected_idx", 32'(w_index), 32'hFFFF);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("w_index", 32'(w_index), 32'(w.index));
                check("w_from_rd", 32'(w_from_rd), 32'(w.from_rd));
            end
        end
    end

    task automatic clear_tlb();
        for (int i = 0; i < TLBNUM; i++) begin
            tlb_e[i] = 1'b0; tlb_g[i] = 1'b0; tlb_vppn[i] = '0;
            tlb_asid[i] = '0; tlb_ps[i] = 6'd12;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic do_req(input logic [2:0] op, input logic [4:0] inv_op,
                          input logic [9:0] asid, input logic [18:0] vppn,
                          input logic [IW-1:0] idx, input int wait_fill,
                          input logic efound, input logic [IW-1:0] eidx,
                          input logic eerr, input int elat);
        resp_t r;
        resp_t e;
        int n;
        if (wait_fill >= 0) begin
            n = 0;
            while (fill_model != IW'(wait_fill) && n < 40) begin
                @(negedge clk);
                n++;
            end
            wq.push_back('{index: fill_model, from_rd: 1'b0});
        end
        e = '{found: efound, index: eidx, err: eerr, lat: elat};
        sb.push_back(e);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_inv_op = inv_op;
        req_asid = asid; req_vppn = vppn; req_index = idx;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("rd_en", 32'(rd_en), 32'(op == 3'd1 && n == 1));
            if (op == 3'd1 && n == 1) check("r_index_rd", 32'(r_index), 32'(idx));
        end while (resp_valid !== 1'b1 && n < 40);
        check("resp_seen", 32'(resp_valid), 32'd1);
        r = sb.pop_front();
        check("resp_latency", 32'(n), 32'(r.lat));
        check("resp_found", 32'(resp_found), 32'(r.found));
        check("resp_index", 32'(resp_index), 32'(r.index));
        check("resp_err", 32'(resp_err), 32'(r.err));
        @(negedge clk);
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
        check("resp_err_held", 32'(resp_err), 32'(r.err));
        check("resp_found_held", 32'(resp_found), 32'(r.found));
        check("writes_drained", 32'(wq.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_inv_op = '0;
        req_asid = '0; req_vppn = '0; req_index = '0;
        s_found = 1'b0; s_index = '0;
        clear_tlb();
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // SRCH hit then miss
        s_found = 1'b1; s_index = 4'd5;
        do_req(3'd0, 5'd0, 10'h12, 19'h1abcd, 4'd0, -1, 1'b1, 4'd5, 1'b0, 2);
        check("s_vppn_held", 32'(s_vppn), 32'h1abcd);
        check("s_asid_held", 32'(s_asid), 32'h12);
        s_found = 1'b0; s_index = 4'd0;
        do_req(3'd0, 5'd0, 10'h34, 19'h00777, 4'd0, -1, 1'b0, 4'd0, 1'b0, 2);

        // RD
        do_req(3'd1, 5'd0, 10'h0, 19'h0, 4'd11, -1, 1'b0, 4'd0, 1'b0, 2);

        // INV op 4: only non-global entry with matching asid is written
        clear_tlb();
        tlb_e[2] = 1'b1; tlb_g[2] = 1'b0; tlb_asid[2] = 10'h3;
        tlb_e[9] = 1'b1; tlb_g[9] = 1'b1; tlb_asid[9] = 10'h3;
        wq.push_back('{index: 4'd2, from_rd: 1'b1});
        do_req(3'd4, 5'd4, 10'h3, 19'h0, 4'd0, -1, 1'b0, 4'd0, 1'b0, TLBNUM + 2);

        // INV op 6: huge page ignores low vppn bits; 4K page does not
        clear_tlb();
        tlb_e[7] = 1'b1; tlb_g[7] = 1'b1; tlb_ps[7] = 6'd21;
        tlb_vppn[7] = 19'h2a5f0 ^ 19'h155; tlb_asid[7] = 10'h99;
        tlb_e[8] = 1'b1; tlb_g[8] = 1'b1; tlb_ps[8] = 6'd12;
        tlb_vppn[8] = 19'h2a5f0 ^ 19'h001; tlb_asid[8] = 10'h99;
        wq.push_back('{index: 4'd7, from_rd: 1'b1});
        do_req(3'd4, 5'd6, 10'h5, 19'h2a5f0, 4'd0, -1, 1'b0, 4'd0, 1'b0, TLBNUM + 2);

        // FILL at counter 15 then 3, then WR index 4
        do_req(3'd3, 5'd0, 10'h0, 19'h0, 4'd0, 15, 1'b0, 4'd0, 1'b0, 2);
        do_req(3'd3, 5'd0, 10'h0, 19'h0, 4'd0, 3, 1'b0, 4'd0, 1'b0, 2);
        wq.push_back('{index: 4'd4, from_rd: 1'b0});
        do_req(3'd2, 5'd0, 10'h0, 19'h0, 4'd4, -1, 1'b0, 4'd0, 1'b0, 2);

        // Illegal INV op and illegal req_op
        do_req(3'd4, 5'd9, 10'h0, 19'h0, 4'd0, -1, 1'b0, 4'd0, 1'b1, 1);
        do_req(3'd7, 5'd0, 10'h0, 19'h0, 4'd0, -1, 1'b0, 4'd0, 1'b1, 1);

        // Reset during scan of INV op 0: entries 0..5 written, then abort
        for (int i = 0; i < TLBNUM; i++) tlb_e[i] = 1'b1;
        for (int i = 0; i < 6; i++) wq.push_back('{index: IW'(i), from_rd: 1'b1});
        req_valid = 1'b1; req_op = 3'd4; req_inv_op = 5'd0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_we", 32'(we), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_writes", 32'(wq.size()), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        s_found = 1'b1; s_index = 4'd13;
        do_req(3'd0, 5'd0, 10'h1, 19'h1, 4'd0, -1, 1'b1, 4'd13, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, giving the number of TLB entries; IW = clog2(TLBNUM).
REQ-002 SHALL have port clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 SHALL have port reset  in  1  reset; one clock, synchronous active-high reset.
REQ-004 SHALL have req_valid  in  1 and req_ready  out  1 as the request handshake.
REQ-005 SHALL have the following request fields:
- req_op  in  3: 0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5-7 are illegal.
- req_inv_op  in  5: INVTLB op code.
- req_asid  in  10.
- req_vppn  in  19.
- req_index  in  IW.
REQ-006 SHALL have these TLB search-port ports:
- s_vppn  out  19.
- s_asid  out  10.
- s_found  in  1.
- s_index  in  IW.
REQ-007 SHALL have these TLB read-port ports:
- r_index  out  IW.
- r_e, r_g  in  1 each.
- r_vppn  in  19.
- r_asid  in  10.
- r_ps  in  6.
REQ-008 SHALL have these TLB write-port ports:
- we  out  1.
- w_index  out  IW.
- w_from_rd  out  1: 1 = the external mux writes the read-port entry with e=0; 0 = it writes the CSR entry.
REQ-009 SHALL have these response ports:
- rd_en  out  1: pulse telling the CSR file to capture read-port data.
- resp_valid  out  1.
- resp_found  out  1.
- resp_index  out  IW.
- resp_err  out  1.

Function
REQ-010 SHALL implement states IDLE, EXEC, SCAN and DONE; req_ready SHALL be 1 only in IDLE.
REQ-011 SHALL latch all req_* fields on accept (req_valid & req_ready in IDLE, cycle T); req_valid outside IDLE SHALL be ignored.
REQ-012 From IDLE, after accept, the next state SHALL be:
- SCAN for INV with a legal req_inv_op (0-6); the scan index starts at 0.
- DONE with resp_err=1 for INV with req_inv_op >6, or for req_op 5-7; no TLB write occurs.
- EXEC for all other ops.
REQ-013 EXEC SHALL last exactly 1 cycle (T+1) and then go to DONE.
REQ-014 In EXEC for SRCH:
- s_vppn and s_asid SHALL drive the latched values.
- s_found and s_index SHALL be registered into resp_found and resp_index.
REQ-015 In EXEC for RD: r_index = latched index and rd_en=1 for that cycle only.
REQ-016 In EXEC for WR: we=1, w_index = latched index, w_from_rd=0.
REQ-017 In EXEC for FILL: we=1, w_from_rd=0, w_index = fill counter value sampled at T.
REQ-018 The fill counter SHALL be IW bits, increment every cycle, wrap from TLBNUM-1 to 0, and reset to 0.
REQ-019 SCAN SHALL visit one entry per cycle, index k at T+1+k for k = 0..TLBNUM-1, driving r_index=k.
REQ-020 During SCAN, if r_e & hit(k): we=1, w_index=k, w_from_rd=1; otherwise we=0.
REQ-021 After index TLBNUM-1, SCAN SHALL go to DONE with no wrap.
REQ-022 hit SHALL be decided by inv_op:
- 0, 1: always.
- 2: r_g.
- 3: !r_g.
- 4: !r_g & asid_eq.
- 5: !r_g & asid_eq & va_eq.
- 6: (r_g | asid_eq) & va_eq.
REQ-023 asid_eq SHALL be r_asid==latched asid.
REQ-024 va_eq SHALL compare bits [18:10] when r_ps==21, and all 19 bits otherwise.
REQ-025 DONE SHALL assert resp_valid=1 for exactly 1 cycle, then go to IDLE; resp_found, resp_index and resp_err SHALL be held until the next accept.
REQ-026 Response latency SHALL be:
- resp_valid at T+2 for SRCH, RD, WR and FILL.
- resp_valid at T+1+TLBNUM+1 for INV.
- resp_valid at T+1 for an illegal op.
REQ-027 resp_found and resp_index SHALL be 0 for non-SRCH ops; resp_err SHALL be 0 except for illegal ops.
REQ-028 we, rd_en and resp_valid SHALL be 0 in IDLE and DONE; at most one write SHALL occur per cycle.
REQ-029 When we=0: w_index, w_from_rd and r_index SHALL be 0 except where REQ-015/REQ-019 drive r_index, and s_vppn/s_asid SHALL hold the latched values.

Reset
REQ-030 While reset=1: state=IDLE, req_ready=0, and we, rd_en, resp_valid, resp_found, resp_index, resp_err and the fill counter SHALL all be 0.
REQ-031 Reset during EXEC or SCAN SHALL abort the operation: no further write, no response; req_ready=1 on the first cycle after reset deasserts.

Verification
REQ-032 A bench SHALL cover these directed scenarios:
- SRCH, with the TLB model hitting entry 5 -> resp_valid at T+2, resp_found=1, resp_index=5; with a miss -> resp_found=0.
- INV op 4, asid=0x3, entries 2 (g=0, asid 3) and 9 (g=1, asid 3) valid -> exactly one write, at w_index=2 with w_from_rd=1; resp_valid at T+18 when TLBNUM=16.
- INV op 6, entry 7 ps=21 with vppn differing only in bits [9:0] from req_vppn and g=1 -> write at index 7.
- FILL accepted when fill counter=15, then FILL accepted when counter=3 -> we with w_index=15 then 3 (wrap verified); WR with index 4 -> w_index=4 and w_from_rd=0.
- INV op 9 -> resp_err=1 at T+1 with no we; req_op=7 -> same.
- reset asserted at scan index 6 of INV op 0 -> no writes after reset; req_valid accepted on the first cycle after reset release.
